sal_ref_ctrl: RTL

SAL_REF_CTRL -- requirements
Module: sal_ref_ctrl

---
 rtl/sal_ddr2_pkg.sv | 32 +++
 rtl/sal_ref_timer.sv | 48 ++++
 rtl/sal_ref_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sal_ddr2_pkg.sv
// Shared SAL DDR2 parameter package.
// Holds the refresh-controller FSM state type and the default DDR2 refresh
// timing constants. Other SAL DDR2 blocks pick these up with
// `import sal_ddr2_pkg::*`.
package sal_ddr2_pkg;

    // Default refresh timing, in controller clocks.
    localparam int unsigned RefTrefiDefault   = 1560;
    localparam int unsigned RefTrpDefault     = 3;
    localparam int unsigned RefTrfcDefault    = 26;
    localparam int unsigned RefMaxPendDefault = 8;
    localparam int unsigned BkCntDefault      = 8;

    // Width of the postponed-refresh counter seen on the pend_cnt port.
    localparam int unsigned RefPendW = 4;

    // Refresh sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StPrea,
        StWaitRp,
        StRef,
        StWaitRfc
    } ref_state_t;

    // Bits needed to hold the values 0..val.
    function automatic int unsigned bits_for(input int unsigned val);
        return (val < 2) ? 1 : $clog2(val + 1);
    endfunction

endpackage

// File: rtl/sal_ref_timer.sv
// tREFI tick generator.
// Counts 0..TREFI-1 while en is high and raises tick for one cycle on the
// wrap cycle. While en is low the count is held at 0 and tick stays low, so
// re-enabling always gives a full TREFI interval before the next tick.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   en   - count enable
//   tick - one-cycle pulse every TREFI enabled cycles
module sal_ref_timer
    import sal_ddr2_pkg::*;
#(
    parameter int unsigned TREFI = RefTrefiDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned     CntW    = bits_for(TREFI - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TREFI - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sal_ref_ctrl.sv
// DDR2 auto-refresh controller.
// Accumulates tREFI ticks as postponed refreshes and, when the banks allow
// it (all idle, or the postpone limit is reached), blocks the bank
// controllers, drains in-flight commands, issues PREA if any row is open,
// waits tRP, issues REF and waits tRFC before releasing the banks.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   ref_en     - refresh enable from configuration
//   bk_busy    - per-bank command in flight
//   bk_open    - per-bank open row
//   bk_block   - bank controllers must not issue new commands while high
//   cmd_valid  - refresh command request to the scheduler
//   cmd_ready  - scheduler accepts the command (transfer on valid & ready)
//   cmd_is_ref - 0 = PREA, 1 = REF
//   pend_cnt   - outstanding refreshes
//   ref_done   - one-cycle pulse in the last tRFC cycle
//   ovf_err    - sticky: a tick was dropped with pend_cnt at MAX_PEND
module sal_ref_ctrl
    import sal_ddr2_pkg::*;
#(
    parameter int unsigned BK_CNT   = BkCntDefault,
    parameter int unsigned TREFI    = RefTrefiDefault,
    parameter int unsigned TRP      = RefTrpDefault,
    parameter int unsigned TRFC     = RefTrfcDefault,
    parameter int unsigned MAX_PEND = RefMaxPendDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ref_en,
    input  logic [BK_CNT-1:0]   bk_busy,
    input  logic [BK_CNT-1:0]   bk_open,
    output logic                bk_block,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                cmd_is_ref,
    output logic [RefPendW-1:0] pend_cnt,
    output logic                ref_done,
    output logic                ovf_err
);

    // One shared down-counter times both WAIT_RP and WAIT_RFC.
    localparam int unsigned      WaitMax = (TRFC > TRP) ? TRFC : TRP;
    localparam int unsigned      WaitW   = bits_for(WaitMax);
    // WAIT_RP spans TRP-1 cycles, counted down to 0 inclusive.
    localparam logic [WaitW-1:0] RpLoad  = WaitW'((TRP > 1) ? (TRP - 2) : 0);
    localparam logic [WaitW-1:0] RfcLoad = WaitW'((TRFC > 0) ? (TRFC - 1) : 0);
    // With TRP of 0 or 1 there is no wait cycle between PREA and REF.
    localparam ref_state_t       PreaNext = (TRP > 1) ? StWaitRp : StRef;

    localparam logic [RefPendW-1:0] PendMax = RefPendW'(MAX_PEND);

    ref_state_t          state_q, state_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [RefPendW-1:0] pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                tick;
    logic                ref_xfer;

    sal_ref_timer #(
        .TREFI (TREFI)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (ref_en),
        .tick (tick)
    );

    // Taken from the state register rather than cmd_valid so the
    // pending-count path does not run through the output decode.
    assign ref_xfer = (state_q == StRef) && cmd_ready;

    // Sequencer: next state and registered-state output decode.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        bk_block   = 1'b1;
        cmd_valid  = 1'b0;
        cmd_is_ref = 1'b0;
        ref_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                bk_block = 1'b0;
                // Start when the banks are idle, or unconditionally once
                // the postpone budget is used up.
                if ((pend_q != '0) && ((bk_busy == '0) || (pend_q == PendMax))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (bk_busy == '0) begin
                    state_d = (bk_open != '0) ? StPrea : StRef;
                end
            end
            StPrea: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    state_d = PreaNext;
                    wait_d  = RpLoad;
                end
            end
            StWaitRp: begin
                if (wait_q == '0) begin
                    state_d = StRef;
                end else begin
                    wait_d = wait_q - WaitW'(1);
                end
            end
            StRef: begin
                cmd_valid  = 1'b1;
                cmd_is_ref = 1'b1;
                if (cmd_ready) begin
                    state_d = StWaitRfc;
                    wait_d  = RfcLoad;
                end
            end
            StWaitRfc: begin
                // Always return to IDLE; a further pending refresh restarts
                // from there rather than chaining here.
                if (wait_q == '0) begin
                    ref_done = 1'b1;
                    state_d  = StIdle;
                end else begin
                    wait_d = wait_q - WaitW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Postponed-refresh accounting.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (ref_xfer && !ref_en) begin
            // Refresh disabled mid-sequence: the in-flight REF finishes and
            // the backlog is discarded.
            pend_d = '0;
        end else if (tick && !ref_xfer) begin
            if (pend_q == PendMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + RefPendW'(1);
            end
        end else if (ref_xfer && !tick && (pend_q != '0)) begin
            pend_d = pend_q - RefPendW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pend_cnt = pend_q;
    assign ovf_err  = ovf_q;

endmodule
